// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller
//  Description : Multi-cycle control unit for a small 16-bit load/store CPU.
//                Moore FSM with a registered state and combinational outputs.
//                It fetches an instruction into IR and advances the 7-bit PC.
//                It then decodes the opcode and sequences the register file,
//                the ALU and the data memory for one instruction at a time.
//  Option      : CPU_CTRL_JMPZ_EN -- when defined, op 1010 executes JMPZ
//                (conditional jump on ALU_zero). When undefined, op 1010
//                is a NOOP.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk         in   1   clock, rising edge
//    Reset       in   1   asynchronous active-high reset
//    IR_in       in  16   instruction word at PC_addr
//    ALU_zero    in   1   ALU result is zero
//    PC_addr     out  7   instruction memory address (= PC)
//    D_addr      out  8   data memory address
//    D_rd        out  1   data memory read strobe
//    D_wr        out  1   data memory write strobe
//    RF_s        out  1   RF write-data select (1 = memory, 0 = ALU)
//    RF_W_addr   out  4   RF write address
//    RF_W_en     out  1   RF write enable
//    RF_Ra_addr  out  4   RF read port A address
//    RF_Rb_addr  out  4   RF read port B address
//    ALU_s0      out  3   ALU function select
//    Halted      out  1   high while halted
// ============================================================================
module cpu_controller (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] IR_in,
   input  logic        ALU_zero,
   output logic [6:0]  PC_addr,
   output logic [7:0]  D_addr,
   output logic        D_rd,
   output logic        D_wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_Ra_addr,
   output logic [3:0]  RF_Rb_addr,
   output logic [2:0]  ALU_s0,
   output logic        Halted
);

   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_LOAD_A = 4'd3,
      ST_LOAD_B = 4'd4,
      ST_STORE  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_JMPZ   = 4'd7,
      ST_HALT   = 4'd8
   } state_t;

   localparam logic [3:0] c_OP_NOOP  = 4'b0000;
   localparam logic [3:0] c_OP_STORE = 4'b0001;
   localparam logic [3:0] c_OP_LOAD  = 4'b0010;
   localparam logic [3:0] c_OP_ADD   = 4'b0011;
   localparam logic [3:0] c_OP_SUB   = 4'b0100;
   localparam logic [3:0] c_OP_XOR   = 4'b0101;
   localparam logic [3:0] c_OP_OR    = 4'b0110;
   localparam logic [3:0] c_OP_AND   = 4'b0111;
   localparam logic [3:0] c_OP_INC   = 4'b1000;
   localparam logic [3:0] c_OP_MOV   = 4'b1001;
   localparam logic [3:0] c_OP_JMPZ  = 4'b1010;
   localparam logic [3:0] c_OP_HALT  = 4'b1111;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_ir;
   logic [6:0]  r_pc;

   logic [3:0]  w_op;
   logic [3:0]  w_ra;
   logic [7:0]  w_addr;
   logic [3:0]  w_rb;
   logic [3:0]  w_rd3;

   assign w_op   = r_ir[15:12];
   assign w_ra   = r_ir[11:8];
   assign w_addr = r_ir[7:0];
   assign w_rb   = r_ir[7:4];
   assign w_rd3  = r_ir[3:0];

   assign PC_addr = r_pc;

   // ------------------------------------------------------------------------
   // State, IR and PC registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_INIT;
         r_ir    <= 16'h0000;
         r_pc    <= 7'd0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_FETCH) begin
            r_ir <= IR_in;
            r_pc <= r_pc + 7'd1;     // 7-bit add wraps 127 -> 0
         end else if ((r_state == ST_JMPZ) && ALU_zero) begin
            // JMPZ is reachable only when the jump option is compiled in,
            // so ALU_zero has no effect otherwise.
            r_pc <= r_ir[6:0];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next state and Moore outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      D_addr     = 8'h00;
      D_rd       = 1'b0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = 4'h0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = 4'h0;
      RF_Rb_addr = 4'h0;
      ALU_s0     = 3'd0;
      Halted     = 1'b0;

      case (r_state)
         ST_INIT: begin
            w_next = ST_FETCH;
         end

         ST_FETCH: begin
            w_next = ST_DECODE;
         end

         ST_DECODE: begin
            case (w_op)
               c_OP_NOOP:  w_next = ST_FETCH;
               c_OP_STORE: w_next = ST_STORE;
               c_OP_LOAD:  w_next = ST_LOAD_A;
               c_OP_ADD, c_OP_SUB, c_OP_XOR, c_OP_OR,
               c_OP_AND, c_OP_INC, c_OP_MOV:
                           w_next = ST_EXEC;
`ifdef CPU_CTRL_JMPZ_EN
               c_OP_JMPZ:  w_next = ST_JMPZ;
`else
               c_OP_JMPZ:  w_next = ST_FETCH;
`endif
               c_OP_HALT:  w_next = ST_HALT;
               default:    w_next = ST_FETCH;
            endcase
         end

         ST_STORE: begin
            D_addr     = w_addr;
            RF_Ra_addr = w_ra;
            D_wr       = 1'b1;
            w_next     = ST_FETCH;
         end

         ST_LOAD_A: begin
            D_addr    = w_addr;
            D_rd      = 1'b1;
            RF_s      = 1'b1;
            RF_W_addr = w_ra;
            w_next    = ST_LOAD_B;
         end

         ST_LOAD_B: begin
            // Memory data has had a full cycle to settle; commit it now.
            D_addr    = w_addr;
            D_rd      = 1'b1;
            RF_s      = 1'b1;
            RF_W_addr = w_ra;
            RF_W_en   = 1'b1;
            w_next    = ST_FETCH;
         end

         ST_EXEC: begin
            RF_Ra_addr = w_ra;
            RF_Rb_addr = w_rb;
            RF_W_addr  = w_rd3;
            RF_s       = 1'b0;
            RF_W_en    = 1'b1;
            case (w_op)
               c_OP_ADD: ALU_s0 = 3'd1;
               c_OP_SUB: ALU_s0 = 3'd2;
               c_OP_XOR: ALU_s0 = 3'd4;
               c_OP_OR:  ALU_s0 = 3'd5;
               c_OP_AND: ALU_s0 = 3'd6;
               c_OP_INC: ALU_s0 = 3'd7;
               c_OP_MOV: ALU_s0 = 3'd3;
               default:  ALU_s0 = 3'd0;
            endcase
            w_next = ST_FETCH;
         end

         ST_JMPZ: begin
            // Pass Ra through the ALU so ALU_zero reflects the register value.
            RF_Ra_addr = w_ra;
            ALU_s0     = 3'd3;
            w_next     = ST_FETCH;
         end

         ST_HALT: begin
            Halted = 1'b1;
            w_next = ST_HALT;
         end

         default: begin
            w_next = ST_INIT;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_controller
//  Description : Scoreboard bench for cpu_controller. A program memory model
//                drives IR_in from PC_addr. Expected strobe cycles (D_rd,
//                D_wr or RF_W_en high) are queued up front. A monitor
//                compares the full output vector of each strobe cycle.
//                Sequencing, PC, halt and reset behaviour are checked
//                directly against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

   logic        clk;
   logic        Reset;
   logic [15:0] IR_in;
   logic        ALU_zero;
   logic [6:0]  PC_addr;
   logic [7:0]  D_addr;
   logic        D_rd;
   logic        D_wr;
   logic        RF_s;
   logic [3:0]  RF_W_addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  ALU_s0;
   logic        Halted;

   logic [15:0] mem [128];
   logic [27:0] exp_q [$];
   int          checks;
   int          failures;

   assign IR_in = mem[PC_addr];

   cpu_controller dut (
      .Clk        (clk),
      .Reset      (Reset),
      .IR_in      (IR_in),
      .ALU_zero   (ALU_zero),
      .PC_addr    (PC_addr),
      .D_addr     (D_addr),
      .D_rd       (D_rd),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .ALU_s0     (ALU_s0),
      .Halted     (Halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [27:0] mk(input logic [7:0] daddr, input logic drd,
                                      input logic dwr, input logic rfs,
                                      input logic [3:0] waddr, input logic wen,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [2:0] alu, input logic halt);
      return {daddr, drd, dwr, rfs, waddr, wen, ra, rb, alu, halt};
   endfunction

   function automatic logic [27:0] outs();
      return {D_addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_en,
              RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted};
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every strobe cycle must match the next queued expectation.
   initial begin
      logic [27:0] e;
      forever begin
         @(negedge clk);
         if (D_rd || D_wr || RF_W_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe actual=%h required=none", outs());
            end else begin
               e = exp_q.pop_front();
               check("strobe_cycle", {4'h0, outs()}, {4'h0, e});
            end
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      #2 Reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      #2 Reset = 1'b0;
   endtask

   // Counts negedges from release until Halted; bounded.
   task automatic wait_halt(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!Halted && n < 60);
   endtask

   int n;
   int exp_cyc;
   logic [6:0] exp_pc;

   initial begin
      checks   = 0;
      failures = 0;
      Reset    = 1'b1;
      ALU_zero = 1'b0;
      clear_mem();

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      check("reset_outputs", {4'h0, outs()}, 32'h0);
      check("reset_pc", {25'h0, PC_addr}, 32'h0);

      // ---------------- NOOP stream: PC 0,1,1,2 ----------------
      release_reset();
      @(negedge clk); check("noop_pc_init", {25'h0, PC_addr}, 32'd0);
      @(negedge clk); check("noop_pc_fetch", {25'h0, PC_addr}, 32'd1);
      @(negedge clk); check("noop_pc_decode", {25'h0, PC_addr}, 32'd1);
      @(negedge clk); check("noop_pc_fetch2", {25'h0, PC_addr}, 32'd2);
      check("noop_not_halted", {31'h0, Halted}, 32'd0);

      // ---------------- ADD, LOAD, STORE, JMPZ(taken), HALT ----------------
      hold_reset();
      clear_mem();
      mem[0]    = 16'h3123;
      mem[1]    = 16'h25A0;
      mem[2]    = 16'h1742;
      mem[3]    = 16'hA015;
      mem[4]    = 16'hF000;
      mem[7'h15] = 16'hF000;
      ALU_zero  = 1'b1;
      exp_q.push_back(mk(8'h00, 0, 0, 0, 4'd3, 1, 4'd1, 4'd2, 3'd1, 0)); // ADD EXEC
      exp_q.push_back(mk(8'hA0, 1, 0, 1, 4'd5, 0, 4'd0, 4'd0, 3'd0, 0)); // LOAD_A
      exp_q.push_back(mk(8'hA0, 1, 0, 1, 4'd5, 1, 4'd0, 4'd0, 3'd0, 0)); // LOAD_B
      exp_q.push_back(mk(8'h42, 0, 1, 0, 4'd0, 0, 4'd7, 4'd0, 3'd0, 0)); // STORE
`ifdef CPU_CTRL_JMPZ_EN
      exp_cyc = 16; exp_pc = 7'h16;
`else
      exp_cyc = 15; exp_pc = 7'h05;
`endif
      release_reset();
      wait_halt(n);
      check("prog1_halt_cycle", n, exp_cyc);
      check("prog1_pc_at_halt", {25'h0, PC_addr}, {25'h0, exp_pc});
      check("prog1_queue_drained", exp_q.size(), 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halt_sticky", {31'h0, Halted}, 32'd1);
      end
      check("halt_pc_frozen", {25'h0, PC_addr}, {25'h0, exp_pc});

      // ---------------- JMPZ not taken ----------------
      hold_reset();
      clear_mem();
      mem[0]   = 16'hA015;
      mem[1]   = 16'hF000;
      mem[7'h15] = 16'hF000;
      ALU_zero = 1'b0;
`ifdef CPU_CTRL_JMPZ_EN
      exp_cyc = 6;
`else
      exp_cyc = 5;
`endif
      release_reset();
      wait_halt(n);
      check("prog2_halt_cycle", n, exp_cyc);
      check("prog2_pc_sequential", {25'h0, PC_addr}, 32'd2);

      // ---------------- PC wrap 127 -> 0 ----------------
      hold_reset();
      clear_mem();
      release_reset();
      repeat (255) @(negedge clk);
      check("wrap_pc_127", {25'h0, PC_addr}, 32'd127);
      @(negedge clk);
      check("wrap_pc_0", {25'h0, PC_addr}, 32'd0);

      // ---------------- reset during LOAD_A ----------------
      hold_reset();
      clear_mem();
      mem[0] = 16'h25A0;
      exp_q.push_back(mk(8'hA0, 1, 0, 1, 4'd5, 0, 4'd0, 4'd0, 3'd0, 0));
      release_reset();
      repeat (3) @(negedge clk);
      check("in_load_a", {31'h0, D_rd}, 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("async_reset_outputs", {4'h0, outs()}, 32'h0);
      check("async_reset_pc", {25'h0, PC_addr}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_held_outputs", {4'h0, outs()}, 32'h0);
      end
      clear_mem();
      release_reset();
      repeat (6) @(negedge clk);
      check("after_reset_no_halt", {31'h0, Halted}, 32'd0);

      check("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The module SHALL have the following ports, one per line as name, direction, width, meaning:
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IR_in  in  16  instruction word from instruction memory, valid combinationally for the current PC_addr.
- ALU_zero  in  1  high when the ALU output Q == 0.
- PC_addr  out  7  instruction memory address; equals the internal PC.
- D_addr  out  8  data memory address.
- D_rd  out  1  data memory read strobe.
- D_wr  out  1  data memory write strobe.
- RF_s  out  1  register file write-data select: 1 = data memory, 0 = ALU Q.
- RF_W_addr  out  4  register file write address.
- RF_W_en  out  1  register file write enable.
- RF_Ra_addr  out  4  register file read port A address.
- RF_Rb_addr  out  4  register file read port B address.
- ALU_s0  out  3  ALU function select: 0 zero, 1 A+B, 2 A-B, 3 pass A, 4 A^B, 5 A|B, 6 A&B, 7 A+1.
- Halted  out  1  high while in state HALT.

Function
REQ-002 The controller SHALL be a Moore FSM with registered state and combinational outputs; the states are INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, EXEC, JMPZ, HALT.
REQ-003 Any output not driven in a state SHALL be 0.
REQ-004 The IR SHALL be a 16-bit register; fields: op = IR[15:12], Ra/Rd = IR[11:8], addr = IR[7:0], Rb = IR[7:4], Rd3 = IR[3:0].
REQ-005 INIT SHALL go to FETCH after one cycle.
REQ-006 FETCH SHALL load IR from IR_in, increment PC modulo 128 (127 wraps to 0), and go to DECODE.
REQ-007 DECODE SHALL branch on op as follows:
- 0000 NOOP goes to FETCH.
- 0001 STORE goes to STORE.
- 0010 LOAD goes to LOAD_A.
- 0011 to 1001 go to EXEC.
- 1010 goes to JMPZ (see REQ-016).
- 1111 goes to HALT.
- Every other op goes to FETCH, behaving as NOOP.
REQ-008 STORE SHALL drive D_addr = addr, RF_Ra_addr = IR[11:8] and D_wr = 1 for exactly one cycle, then go to FETCH.
REQ-009 LOAD_A SHALL drive D_addr = addr, D_rd = 1, RF_s = 1 and RF_W_addr = IR[11:8], then go to LOAD_B.
REQ-010 LOAD_B SHALL hold the LOAD_A outputs and additionally assert RF_W_en = 1, then go to FETCH.
REQ-011 EXEC SHALL drive RF_Ra_addr = IR[11:8], RF_Rb_addr = Rb, RF_W_addr = Rd3, RF_s = 0, RF_W_en = 1 and ALU_s0 by op, then go to FETCH.
REQ-012 The EXEC ALU_s0 mapping SHALL be: 0011 = 1, 0100 = 2, 0101 = 4, 0110 = 5, 0111 = 6, 1000 = 7, 1001 = 3.
REQ-013 HALT SHALL assert Halted and remain in HALT until Reset.
REQ-014 Instruction latency SHALL be, counted FETCH through last state: NOOP 2 cycles, STORE/EXEC/JMPZ 3 cycles, LOAD 4 cycles.

Reset
REQ-015 On Reset assertion, in any state including mid-instruction, state SHALL go to INIT, PC to 0 and IR to 0, immediately and independent of Clk; all outputs SHALL read 0 while Reset is held, and no D_wr or RF_W_en pulse SHALL occur.

Configuration
REQ-016 Macro CPU_CTRL_JMPZ_EN:
- When defined, op 1010 SHALL enter JMPZ, which drives RF_Ra_addr = IR[11:8] and ALU_s0 = 3.
- In JMPZ, if ALU_zero = 1, PC SHALL load IR[6:0]; otherwise PC SHALL be unchanged.
- JMPZ SHALL then go to FETCH.
- When not defined, op 1010 SHALL behave as NOOP and ALU_zero SHALL be ignored.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Reset, then release with IR_in = 0x0000 -> INIT, FETCH, DECODE, FETCH; PC_addr steps 0, 1, 2.
- IR_in = 0x3123 (ADD) -> EXEC cycle with Ra = 1, Rb = 2, RF_W_addr = 3, ALU_s0 = 1, RF_W_en = 1, RF_s = 0.
- IR_in = 0x25A0 (LOAD) -> LOAD_A: D_addr = 0xA0, D_rd = 1, RF_s = 1; LOAD_B: RF_W_en = 1 with RF_W_addr = 5.
- IR_in = 0x1742 (STORE) -> exactly one D_wr pulse, D_addr = 0x42, RF_Ra_addr = 7.
- PC = 127 at FETCH -> PC_addr = 0 next.
- IR_in = 0xF000 -> Halted = 1 and stays high indefinitely.
- Reset asserted during LOAD_A -> outputs 0 asynchronously, no RF_W_en.
- With the macro defined, IR_in = 0xA015 and ALU_zero = 1 -> next PC_addr = 0x15.
- With the macro defined, IR_in = 0xA015 and ALU_zero = 0 -> PC continues sequentially.
